// File: rtl/raydir_gen_pkg.sv
// Shared fixed-point constants and FSM encoding for the ray-direction generator.
// Vectors are 24-bit SQ12.12 values.
package raydir_gen_pkg;

    localparam int unsigned F_W               = 24;
    localparam int unsigned F_FRAC            = 12;
    localparam int unsigned COLS_LOG2_DEFAULT = 9;
    localparam int unsigned FRAC_EXT_DEFAULT  = 8;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_RUN  = 1'b1
    } rd_state_e;

endpackage

// File: rtl/raydir_axis.sv
// Per-axis ray-direction accumulator: initialises from facing/vplane, steps without a multiplier.
// RAYDIR_MIRROR_EN selects right-to-left traversal.
module raydir_axis
    import raydir_gen_pkg::*;
#(
    parameter int unsigned COLS_LOG2 = COLS_LOG2_DEFAULT,
    parameter int unsigned FRAC_EXT  = FRAC_EXT_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic           advance,
    input  logic [F_W-1:0] facing,
    input  logic [F_W-1:0] vplane,
    output logic [F_W-1:0] ray_dir
);

    localparam int unsigned AccW = 25 + FRAC_EXT;

    logic signed [AccW-1:0] facing_sc;
    logic signed [AccW-1:0] vplane_sc;
    logic signed [AccW-1:0] step_init;
    logic signed [AccW-1:0] acc_init;
    logic signed [AccW-1:0] step_load;
    logic signed [AccW-1:0] acc_q, acc_d;
    logic signed [AccW-1:0] step_q, step_d;

    always_comb begin
        facing_sc = $signed({{(AccW-F_W){facing[F_W-1]}}, facing}) <<< FRAC_EXT;
        vplane_sc = $signed({{(AccW-F_W){vplane[F_W-1]}}, vplane}) <<< FRAC_EXT;
        // 2*vplane/COLS per column, exact while FRAC_EXT >= COLS_LOG2-1
        step_init = vplane_sc >>> (COLS_LOG2 - 1);
`ifdef RAYDIR_MIRROR_EN
        acc_init  = facing_sc + vplane_sc - step_init;
        step_load = -step_init;
`else
        acc_init  = facing_sc - vplane_sc;
        step_load = step_init;
`endif
    end

    always_comb begin
        acc_d  = acc_q;
        step_d = step_q;
        if (load) begin
            acc_d  = acc_init;
            step_d = step_load;
        end else if (advance) begin
            acc_d = acc_q + step_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            step_q <= '0;
        end else begin
            acc_q  <= acc_d;
            step_q <= step_d;
        end
    end

    assign ray_dir = F_W'(acc_q >>> FRAC_EXT);

endmodule

// File: rtl/raydir_gen.sv
// Per-column ray-direction generator: frame FSM, column counter and valid/ready handshake.
// Build with RAYDIR_MIRROR_EN for right-to-left traversal.
module raydir_gen
    import raydir_gen_pkg::*;
#(
    parameter int unsigned COLS_LOG2 = COLS_LOG2_DEFAULT,
    parameter int unsigned FRAC_EXT  = FRAC_EXT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [F_W-1:0]       facingX,
    input  logic [F_W-1:0]       facingY,
    input  logic [F_W-1:0]       vplaneX,
    input  logic [F_W-1:0]       vplaneY,
    output logic [F_W-1:0]       rayDirX,
    output logic [F_W-1:0]       rayDirY,
    output logic [COLS_LOG2-1:0] col,
    output logic                 valid,
    input  logic                 ready,
    output logic                 busy,
    output logic                 load_if_ready
);

    rd_state_e            state_q, state_d;
    logic [COLS_LOG2-1:0] col_q, col_d;
    logic                 valid_q, valid_d;
    logic                 load_q, load_d;
    logic                 xfer;
    logic                 last_col;
    logic                 latch;
    logic                 advance;

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        valid_d  = valid_q;
        load_d   = 1'b0;
        latch    = 1'b0;
        advance  = 1'b0;
        xfer     = valid_q && ready;
        last_col = (col_q == {COLS_LOG2{1'b1}});

        // Final acceptance pulses even if a restart wins the same cycle
        if (state_q == RD_RUN && xfer && last_col) begin
            load_d = 1'b1;
        end

        if (start) begin
            latch   = 1'b1;
            state_d = RD_RUN;
            col_d   = '0;
            valid_d = 1'b1;
        end else if (state_q == RD_RUN && xfer) begin
            if (last_col) begin
                state_d = RD_IDLE;
                valid_d = 1'b0;
                col_d   = '0;
            end else begin
                col_d   = col_q + COLS_LOG2'(1);
                advance = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RD_IDLE;
            col_q   <= '0;
            valid_q <= 1'b0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            valid_q <= valid_d;
            load_q  <= load_d;
        end
    end

    raydir_axis #(
        .COLS_LOG2 (COLS_LOG2),
        .FRAC_EXT  (FRAC_EXT)
    ) u_axis_x (
        .clk     (clk),
        .reset   (reset),
        .load    (latch),
        .advance (advance),
        .facing  (facingX),
        .vplane  (vplaneX),
        .ray_dir (rayDirX)
    );

    raydir_axis #(
        .COLS_LOG2 (COLS_LOG2),
        .FRAC_EXT  (FRAC_EXT)
    ) u_axis_y (
        .clk     (clk),
        .reset   (reset),
        .load    (latch),
        .advance (advance),
        .facing  (facingY),
        .vplane  (vplaneY),
        .ray_dir (rayDirY)
    );

    assign col           = col_q;
    assign valid         = valid_q;
    assign busy          = (state_q == RD_RUN);
    assign load_if_ready = load_q;

endmodule

// File: tb/tb_raydir_gen.sv
// Self-checking bench for raydir_gen against an arithmetic model of facing + vplane*(2c/COLS - 1).
module tb_raydir_gen;

    localparam int COLS_LOG2 = 9;
    localparam int COLS      = 512;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        ready;
    logic [23:0] fx, fy, vx, vy;
    logic [23:0] rdx, rdy;
    logic [8:0]  col;
    logic        valid, busy, load_if_ready;

    int n_cmp = 0;
    int n_bad = 0;

    raydir_gen dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .facingX       (fx),
        .facingY       (fy),
        .vplaneX       (vx),
        .vplaneY       (vy),
        .rayDirX       (rdx),
        .rayDirY       (rdy),
        .col           (col),
        .valid         (valid),
        .ready         (ready),
        .busy          (busy),
        .load_if_ready (load_if_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Exact ray for screen position c; mirrored builds show position COLS-1-c at column c
    function automatic logic [23:0] ref_dir(input logic [23:0] f, input logic [23:0] v,
                                            input int c);
        longint fs, vs, num, k;
        logic [63:0] t;
        fs = longint'($signed(f));
        vs = longint'($signed(v));
`ifdef RAYDIR_MIRROR_EN
        k = longint'(COLS - 1 - c);
`else
        k = longint'(c);
`endif
        num = fs * COLS + vs * (2 * k - COLS);
        t = 64'(num >>> COLS_LOG2);
        return t[23:0];
    endfunction

    function automatic logic [23:0] rnd_vec();
        return 24'($urandom_range(0, 16383)) - 24'd8192;
    endfunction

    // Drive start for one cycle; column 0 is on the outputs afterwards
    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_valid", 32'(valid), 32'd1);
        chk("start_col", 32'(col), 32'd0);
        chk("start_busy", 32'(busy), 32'd1);
    endtask

    // Consume a frame from column 0, checking every column, stalls and the final pulse
    task automatic run_frame(input bit bp);
        int          exp_col;
        int          xfers;
        int          cyc;
        bit          done;
        bit          stalled;
        bit          x;
        logic [23:0] px, py;
        logic [8:0]  pc;
        exp_col = 0;
        xfers   = 0;
        cyc     = 0;
        done    = 1'b0;
        stalled = 1'b0;
        px      = '0;
        py      = '0;
        pc      = '0;
        while (!done && cyc < 5000) begin
            if (stalled) begin
                chk("stall_x", 32'(rdx), 32'(px));
                chk("stall_y", 32'(rdy), 32'(py));
                chk("stall_col", 32'(pc), 32'(col));
            end
            chk("run_valid", 32'(valid), 32'd1);
            chk("run_col", 32'(col), 32'(exp_col));
            chk("run_x", 32'(rdx), 32'(ref_dir(fx, vx, exp_col)));
            chk("run_y", 32'(rdy), 32'(ref_dir(fy, vy, exp_col)));
            ready   = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            x       = valid && ready;
            stalled = valid && !ready;
            px      = rdx;
            py      = rdy;
            pc      = col;
            // Mid-frame input changes must be ignored
            fx      = fx ^ 24'h000010;
            tick();
            fx      = fx ^ 24'h000010;
            cyc++;
            if (x) begin
                xfers++;
                if (exp_col == COLS - 1) begin
                    chk("end_load", 32'(load_if_ready), 32'd1);
                    chk("end_valid", 32'(valid), 32'd0);
                    chk("end_busy", 32'(busy), 32'd0);
                    done = 1'b1;
                end else begin
                    chk("mid_load", 32'(load_if_ready), 32'd0);
                    exp_col++;
                end
            end
        end
        chk("frame_done", 32'(done), 32'd1);
        chk("frame_xfers", 32'(xfers), 32'(COLS));
        tick();
        chk("load_one_cycle", 32'(load_if_ready), 32'd0);
        chk("idle_valid", 32'(valid), 32'd0);
    endtask

    // Advance with ready=1 until col reaches target; returns count of load pulses seen
    task automatic run_to(input int target, output int pulses);
        int cyc;
        cyc    = 0;
        pulses = 0;
        ready  = 1'b1;
        while (int'(col) != target && cyc < 2000) begin
            tick();
            cyc++;
            if (load_if_ready) pulses++;
        end
        chk("reach_col", 32'(col), 32'(target));
    endtask

    initial begin
        int pulses;
        reset = 1'b1;
        start = 1'b0;
        ready = 1'b0;
        fx    = 24'h000000;
        fy    = 24'h001000;
        vx    = 24'hFFF800;
        vy    = 24'h000000;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_col", 32'(col), 32'd0);
        chk("rst_x", 32'(rdx), 32'd0);
        chk("rst_y", 32'(rdy), 32'd0);
        chk("rst_load", 32'(load_if_ready), 32'd0);

        // Directed frame: facing (0,1), vplane (-0.5,0)
        do_start();
`ifdef RAYDIR_MIRROR_EN
        chk("dir_col0_x", 32'(rdx), 32'h00FFF808);
`else
        chk("dir_col0_x", 32'(rdx), 32'h00000800);
`endif
        chk("dir_col0_y", 32'(rdy), 32'h00001000);
        run_frame(1'b0);

        // Random vectors with random backpressure
        for (int i = 0; i < 3; i++) begin
            fx = rnd_vec();
            fy = rnd_vec();
            vx = rnd_vec();
            vy = rnd_vec();
            do_start();
            run_frame(1'b1);
        end

        // Restart at column 100 with vplane (0, 0.5)
        fx = 24'h000000;
        fy = 24'h001000;
        vx = 24'hFFF800;
        vy = 24'h000000;
        do_start();
        run_to(100, pulses);
        vx    = 24'h000000;
        vy    = 24'h000800;
        fy    = 24'h000000;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rs_valid", 32'(valid), 32'd1);
        chk("rs_col", 32'(col), 32'd0);
        chk("rs_x", 32'(rdx), 32'h00000000);
        chk("rs_y", 32'(rdy), 32'(ref_dir(fy, vy, 0)));
        chk("rs_load", 32'(load_if_ready + pulses), 32'd0);
        run_frame(1'b1);

        // Reset at column 300
        fx = rnd_vec();
        vx = rnd_vec();
        do_start();
        run_to(300, pulses);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mrst_valid", 32'(valid), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_col", 32'(col), 32'd0);
        chk("mrst_x", 32'(rdx), 32'd0);
        chk("mrst_y", 32'(rdy), 32'd0);
        chk("mrst_load", 32'(load_if_ready + pulses), 32'd0);
        tick();
        chk("mrst_load2", 32'(load_if_ready), 32'd0);
        chk("mrst_valid2", 32'(valid), 32'd0);

        // Start coincident with the final transfer
        fy = rnd_vec();
        vy = rnd_vec();
        do_start();
        run_to(COLS - 1, pulses);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("co_load", 32'(load_if_ready), 32'd1);
        chk("co_valid", 32'(valid), 32'd1);
        chk("co_col", 32'(col), 32'd0);
        chk("co_x", 32'(rdx), 32'(ref_dir(fx, vx, 0)));
        run_frame(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
